sr_bank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one N-bit bank of set/reset D flip-flop cells (per-bit R, S, D inputs; Q and val = Q^QN outputs) between two requesters, A and B.
- Converts each granted command (load, masked clear, masked preset, read) into legal per-bit R/S/D drive. R=S=1 is never driven.
- Reads back the bank after every command and checks the result against the expected value and against the per-bit val lines.
- Sits between the bank and two client blocks.

---
 rtl/sr_bank_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sr_bank_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin sharing of one set/reset D flip-flop bank
// between requesters A and B. Each granted command is turned into legal
// per-bit R/S/D drive, and the bank is read back and checked afterwards.
module sr_bank_arbiter #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         R,
  input  logic         A_REQ,
  input  logic [1:0]   A_OP,
  input  logic [N-1:0] A_DATA,
  output logic         A_GNT,
  output logic         A_DONE,
  input  logic         B_REQ,
  input  logic [1:0]   B_OP,
  input  logic [N-1:0] B_DATA,
  output logic         B_GNT,
  output logic         B_DONE,
  output logic [N-1:0] RDATA,
  output logic         ERR,
  output logic         BUSY,
  output logic [N-1:0] BR,
  output logic [N-1:0] BS,
  output logic [N-1:0] BD,
  input  logic [N-1:0] BQ,
  input  logic [N-1:0] BVAL
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t       state_r, state_nx_s;
  logic         grant_s, win_b_s, owner_nx_s;
  logic [1:0]   op_r;
  logic [N-1:0] data_r, old_r, exp_s;
  logic         owner_r;   // 0 = A, 1 = B
  logic         last_r;    // last winner, 0 = A, 1 = B
  logic         a_gnt_nx_s, b_gnt_nx_s, a_done_nx_s, b_done_nx_s, busy_nx_s;
  logic [N-1:0] rdata_nx_s;
  logic         err_nx_s;

  // State register
  always_ff @(posedge CLK) begin
    if (R) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and round-robin arbitration; the winner is whoever is not LAST
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    win_b_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (A_REQ && (!B_REQ || last_r)) begin
          grant_s    = 1'b1;
          win_b_s    = 1'b0;
          state_nx_s = APPLY;
        end else if (B_REQ) begin
          grant_s    = 1'b1;
          win_b_s    = 1'b1;
          state_nx_s = APPLY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      APPLY:   state_nx_s = CHECK;
      CHECK:   state_nx_s = RESP;
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Expected bank contents after the latched command
  always_comb begin
    exp_s = old_r;
    case (op_r)
      OP_LOAD:   exp_s = data_r;
      OP_CLEAR:  exp_s = old_r & ~data_r;
      OP_PRESET: exp_s = old_r | data_r;
      OP_READ:   exp_s = old_r;
      default:   exp_s = old_r;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    owner_nx_s  = grant_s ? win_b_s : owner_r;
    a_gnt_nx_s  = ((state_nx_s == APPLY) || (state_nx_s == CHECK)) && !owner_nx_s;
    b_gnt_nx_s  = ((state_nx_s == APPLY) || (state_nx_s == CHECK)) && owner_nx_s;
    a_done_nx_s = (state_nx_s == RESP) && !owner_nx_s;
    b_done_nx_s = (state_nx_s == RESP) && owner_nx_s;
    busy_nx_s   = (state_nx_s != IDLE);
    rdata_nx_s  = RDATA;
    err_nx_s    = ERR;
    if (state_r == CHECK) begin
      rdata_nx_s = BQ;
      err_nx_s   = (BQ != exp_s) | ~&BVAL;
    end else begin
      rdata_nx_s = RDATA;
      err_nx_s   = ERR;
    end
  end

  // Output registers and command latch
  always_ff @(posedge CLK) begin
    if (R) begin
      A_GNT   <= 1'b0;
      B_GNT   <= 1'b0;
      A_DONE  <= 1'b0;
      B_DONE  <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= '0;
      last_r  <= 1'b1;
      owner_r <= 1'b0;
      op_r    <= OP_READ;
      data_r  <= '0;
      old_r   <= '0;
    end else begin
      A_GNT  <= a_gnt_nx_s;
      B_GNT  <= b_gnt_nx_s;
      A_DONE <= a_done_nx_s;
      B_DONE <= b_done_nx_s;
      BUSY   <= busy_nx_s;
      ERR    <= err_nx_s;
      RDATA  <= rdata_nx_s;
      if (grant_s) begin
        last_r  <= win_b_s;
        owner_r <= win_b_s;
        op_r    <= win_b_s ? B_OP : A_OP;
        data_r  <= win_b_s ? B_DATA : A_DATA;
        old_r   <= BQ;
      end else begin
        last_r  <= last_r;
        owner_r <= owner_r;
        op_r    <= op_r;
        data_r  <= data_r;
        old_r   <= old_r;
      end
    end
  end

  // Bank drive: clear during reset, command drive in APPLY, hold otherwise
  always_comb begin
    BR = '0;
    BS = '0;
    BD = BQ;
    if (R) begin
      BR = '1;
      BS = '0;
      BD = '0;
    end else if (state_r == APPLY) begin
      case (op_r)
        OP_LOAD: begin
          BR = '0;
          BS = '0;
          BD = data_r;
        end
        OP_CLEAR: begin
          BR = data_r;
          BS = '0;
          BD = BQ;
        end
        OP_PRESET: begin
          BR = '0;
          BS = data_r;
          BD = BQ;
        end
        OP_READ: begin
          BR = '0;
          BS = '0;
          BD = BQ;
        end
        default: begin
          BR = '0;
          BS = '0;
          BD = BQ;
        end
      endcase
    end else begin
      BR = '0;
      BS = '0;
      BD = BQ;
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter with a behavioural SR-DFF bank model.
module tb_sr_bank_arbiter;

  localparam logic [1:0] LOAD   = 2'b00;
  localparam logic [1:0] CLEAR  = 2'b01;
  localparam logic [1:0] PRESET = 2'b10;
  localparam logic [1:0] READ   = 2'b11;

  logic       CLK = 1'b0;
  logic       R = 1'b1;
  logic       A_REQ = 1'b0, B_REQ = 1'b0;
  logic [1:0] A_OP = 2'b00, B_OP = 2'b00;
  logic [7:0] A_DATA = 8'h00, B_DATA = 8'h00;
  logic       A_GNT, A_DONE, B_GNT, B_DONE, ERR, BUSY;
  logic [7:0] RDATA, BR, BS, BD, BQ, BVAL;

  logic [7:0] bank_q = 8'hFF;
  logic       bq_force_en = 1'b0;
  logic [7:0] bq_force_val = 8'h00;
  logic [7:0] bval_clr = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Bank of SR D flip-flops: reset dominates, then set, then data
  always @(posedge CLK) bank_q <= ~BR & (BS | BD);

  assign BQ   = bq_force_en ? bq_force_val : bank_q;
  assign BVAL = ~bval_clr;

  sr_bank_arbiter #(.N(8)) dut (
    .CLK(CLK), .R(R),
    .A_REQ(A_REQ), .A_OP(A_OP), .A_DATA(A_DATA), .A_GNT(A_GNT), .A_DONE(A_DONE),
    .B_REQ(B_REQ), .B_OP(B_OP), .B_DATA(B_DATA), .B_GNT(B_GNT), .B_DONE(B_DONE),
    .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY),
    .BR(BR), .BS(BS), .BD(BD), .BQ(BQ), .BVAL(BVAL)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete command from the given requester; fault 1 drops BVAL[3],
  // fault 2 forces BQ to 0xA7, both only during the CHECK cycle.
  task automatic run_cmd(input logic is_b, input logic [1:0] op, input logic [7:0] data,
                         input logic [7:0] exp_rd, input logic exp_err, input int fault,
                         input string tag);
    logic [7:0] exp_br;
    logic [7:0] exp_bs;
    logic [1:0] exp_own;
    exp_br  = (op == CLEAR)  ? data : 8'h00;
    exp_bs  = (op == PRESET) ? data : 8'h00;
    exp_own = is_b ? 2'b01 : 2'b10;
    if (is_b) begin
      B_REQ = 1'b1; B_OP = op; B_DATA = data;
    end else begin
      A_REQ = 1'b1; A_OP = op; A_DATA = data;
    end
    @(posedge CLK); #1;
    A_REQ = 1'b0; B_REQ = 1'b0;
    A_OP = 2'b11; B_OP = 2'b11; A_DATA = 8'h00; B_DATA = 8'h00;
    chk({tag, "_apply_gnt"}, {A_GNT, B_GNT}, exp_own);
    chk({tag, "_apply_busy"}, BUSY, 1'b1);
    chk({tag, "_apply_br"}, BR, exp_br);
    chk({tag, "_apply_bs"}, BS, exp_bs);
    chk({tag, "_apply_brbs"}, BR & BS, 8'h00);
    if (op == LOAD) chk({tag, "_apply_bd"}, BD, data);
    @(posedge CLK); #1;
    if (fault == 1) bval_clr = 8'h08;
    if (fault == 2) begin
      bq_force_en = 1'b1; bq_force_val = 8'hA7;
    end
    chk({tag, "_check_gnt"}, {A_GNT, B_GNT}, exp_own);
    chk({tag, "_check_br"}, BR | BS, 8'h00);
    chk({tag, "_check_done"}, {A_DONE, B_DONE}, 2'b00);
    @(posedge CLK); #1;
    bval_clr = 8'h00; bq_force_en = 1'b0;
    chk({tag, "_resp_done"}, {A_DONE, B_DONE}, exp_own);
    chk({tag, "_resp_gnt"}, {A_GNT, B_GNT}, 2'b00);
    chk({tag, "_resp_rdata"}, RDATA, exp_rd);
    chk({tag, "_resp_err"}, ERR, exp_err);
    chk({tag, "_resp_busy"}, BUSY, 1'b1);
    @(posedge CLK); #1;
    chk({tag, "_idle_done"}, {A_DONE, B_DONE}, 2'b00);
    chk({tag, "_idle_busy"}, BUSY, 1'b0);
    chk({tag, "_idle_rdata_hold"}, RDATA, exp_rd);
  endtask

  initial begin
    // Reset with the bank preset to 0xFF
    #1;
    chk("rst_br0", BR, 8'hFF);
    @(posedge CLK); #1;
    chk("rst_br1", BR, 8'hFF);
    chk("rst_bs", BS, 8'h00);
    @(posedge CLK); #1;
    R = 1'b0;
    #1;
    chk("rst_bq", BQ, 8'h00);
    chk("rst_outs", {A_GNT, B_GNT, A_DONE, B_DONE, ERR, BUSY}, 6'b000000);
    chk("rst_rdata", RDATA, 8'h00);
    chk("rst_br_rel", BR, 8'h00);

    // Basic load, then masked clear and preset
    run_cmd(1'b0, LOAD,   8'hA5, 8'hA5, 1'b0, 0, "a_load");
    run_cmd(1'b0, CLEAR,  8'h0F, 8'hA0, 1'b0, 0, "a_clear");
    run_cmd(1'b1, PRESET, 8'h03, 8'hA3, 1'b0, 0, "b_preset");
    chk("bank_a3", BQ, 8'hA3);

    // Contention: both requests held for four commands, grants alternate A,B,A,B
    A_OP = LOAD; A_DATA = 8'h11; B_OP = LOAD; B_DATA = 8'h22;
    A_REQ = 1'b1; B_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("cont_gnt_apply", {A_GNT, B_GNT}, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge CLK); #1;
      chk("cont_gnt_check", {A_GNT, B_GNT}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("cont_nodone", {A_DONE, B_DONE}, 2'b00);
      @(posedge CLK); #1;
      chk("cont_done", {A_DONE, B_DONE}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("cont_rdata", RDATA, (i % 2 == 0) ? 8'h11 : 8'h22);
      @(posedge CLK); #1;
      chk("cont_idle", {A_DONE, B_DONE, BUSY}, 3'b000);
      if (i == 3) begin
        A_REQ = 1'b0; B_REQ = 1'b0;
      end
    end

    // Zero-mask no-op, read with a val fault, load with a Q fault
    run_cmd(1'b1, LOAD,   8'hA3, 8'hA3, 1'b0, 0, "b_load_a3");
    run_cmd(1'b0, READ,   8'h00, 8'hA3, 1'b1, 1, "a_read_valfault");
    run_cmd(1'b1, PRESET, 8'h00, 8'hA3, 1'b0, 0, "b_preset_zero");
    run_cmd(1'b0, CLEAR,  8'h00, 8'hA3, 1'b0, 0, "a_clear_zero");
    run_cmd(1'b0, LOAD,   8'hA3, 8'hA7, 1'b1, 2, "a_load_qfault");

    // Reset during APPLY of a B load aborts it
    B_OP = LOAD; B_DATA = 8'h3C; B_REQ = 1'b1;
    @(posedge CLK); #1;
    B_REQ = 1'b0;
    chk("abort_gnt", B_GNT, 1'b1);
    R = 1'b1;
    #1;
    chk("abort_br", BR, 8'hFF);
    chk("abort_bsbd", {BS, BD}, 16'h0000);
    @(posedge CLK); #1;
    R = 1'b0;
    #1;
    chk("abort_bank", BQ, 8'h00);
    chk("abort_state", {A_GNT, B_GNT, BUSY}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("abort_nodone", {A_DONE, B_DONE}, 2'b00);
    end

    // Simultaneous request after reset: A wins
    B_OP = LOAD; B_DATA = 8'hC3; B_REQ = 1'b1;
    run_cmd(1'b0, LOAD, 8'h5A, 8'h5A, 1'b0, 0, "post_rst_a_wins");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
